// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: walks two wide operands CHUNK bits per cycle,
// most-significant slice first, and stops at the first slice that differs.
module seq_comparator #(
    parameter int N_WIDTH = 32,
    parameter int CHUNK   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_WIDTH-1:0] a,
    input  logic [N_WIDTH-1:0] b,
    input  logic               sgn,
    output logic               busy,
    output logic               done,
    output logic               gt,
    output logic               lt,
    output logic               eq
);

    localparam int NCHUNK = N_WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    generate
        if ((N_WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_comparator: N_WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [N_WIDTH-1:0] a_q, a_d;
    logic [N_WIDTH-1:0] b_q, b_d;
    logic               sgn_q, sgn_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;

    logic               flip_s;
    logic [CHUNK-1:0]   slice_a_s;
    logic [CHUNK-1:0]   slice_b_s;

    // Slice under test is always the top CHUNK bits, since operands shift left as
    // slices match; the sign-bit inversion applies only to the first slice.
    always_comb begin
        flip_s    = sgn_q & (idx_q == {IDXW{1'b0}});
        slice_a_s = a_q[N_WIDTH-1 -: CHUNK] ^ (flip_s ? MSB_MASK : {CHUNK{1'b0}});
        slice_b_s = b_q[N_WIDTH-1 -: CHUNK] ^ (flip_s ? MSB_MASK : {CHUNK{1'b0}});
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = sgn;
                    idx_d   = {IDXW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = CMP;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            CMP: begin
                if (slice_a_s != slice_b_s) begin
                    gt_d    = (slice_a_s > slice_b_s);
                    lt_d    = (slice_a_s < slice_b_s);
                    eq_d    = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == LAST_IDX) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    a_d     = a_q << CHUNK;
                    b_d     = b_q << CHUNK;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= {IDXW{1'b0}};
            a_q     <= {N_WIDTH{1'b0}};
            b_q     <= {N_WIDTH{1'b0}};
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Self-checking bench for seq_comparator (16-bit operands, 4-bit slices) against
// an arithmetic reference model.
module tb_seq_comparator;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int NC = W / C;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         sgn   = 1'b0;
    logic [W-1:0] a     = 16'h0000;
    logic [W-1:0] b     = 16'h0000;
    logic         busy, done, gt, lt, eq;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_cyc;
    int pend_lat;
    bit pend_gt, pend_lt, pend_eq;
    bit cur_gt = 1'b0, cur_lt = 1'b0, cur_eq = 1'b0;

    seq_comparator #(.N_WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .sgn(sgn),
        .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: ordering from plain signed/unsigned arithmetic; latency from the
    // position of the first differing slice (last slice if all match).
    task automatic model_op(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
        int j;
        j = NC - 1;
        for (int i = NC - 1; i >= 0; i--) begin
            if (ma[W-1-C*i -: C] != mb[W-1-C*i -: C]) j = i;
        end
        pend_lat = j + 1;
        if (ms) begin
            pend_gt = ($signed(ma) > $signed(mb));
            pend_lt = ($signed(ma) < $signed(mb));
        end else begin
            pend_gt = (ma > mb);
            pend_lt = (ma < mb);
        end
        pend_eq = (ma == mb);
    endtask

    // Called #1 after an edge with the block idle (or in its done cycle).
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                          input bit hold, input string nm);
        start = 1'b1; a = ta; b = tb_v; sgn = ts;
        model_op(ta, tb_v, ts);
        @(posedge clk); #1;
        acc_cyc = cyc;
        if (!hold) start = 1'b0;
        a = W'($urandom); b = W'($urandom); sgn = 1'($urandom);
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s accept: busy=%b done=%b expected busy=1 done=0", nm, busy, done);
        end
    endtask

    task automatic await_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 4 * NC + 4 && !seen; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                n_cmp++;
                if (busy !== 1'b1 || {gt, lt, eq} !== {cur_gt, cur_lt, cur_eq}) begin
                    n_err++;
                    $display("FAIL %s hold: busy=%b gt/lt/eq=%b%b%b expected busy=1 gt/lt/eq=%b%b%b",
                             nm, busy, gt, lt, eq, cur_gt, cur_lt, cur_eq);
                end
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s timeout: no done within bound", nm);
        end else begin
            if (cyc - acc_cyc !== pend_lat) begin
                n_err++;
                $display("FAIL %s latency: got %0d cycles expected %0d", nm, cyc - acc_cyc, pend_lat);
            end
            n_cmp++;
            if ({gt, lt, eq} !== {pend_gt, pend_lt, pend_eq} || busy !== 1'b0) begin
                n_err++;
                $display("FAIL %s result: gt/lt/eq=%b%b%b busy=%b expected %b%b%b busy=0",
                         nm, gt, lt, eq, busy, pend_gt, pend_lt, pend_eq);
            end
        end
        cur_gt = pend_gt; cur_lt = pend_lt; cur_eq = pend_eq;
    endtask

    task automatic check_idle(input string nm);
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || {gt, lt, eq} !== {cur_gt, cur_lt, cur_eq}) begin
            n_err++;
            $display("FAIL %s idle: done=%b busy=%b gt/lt/eq=%b%b%b expected 0 0 %b%b%b",
                     nm, done, busy, gt, lt, eq, cur_gt, cur_lt, cur_eq);
        end
    endtask

    task automatic test_reset();
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; sgn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, gt, lt, eq} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_state: busy/done/gt/lt/eq=%b%b%b%b%b expected 00000", busy, done, gt, lt, eq);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check_idle("reset_release");
    endtask

    task automatic test_equal();
        launch(16'h1234, 16'h1234, 1'b0, 1'b0, "equal");
        await_done("equal");
        check_idle("equal_after");
    endtask

    task automatic test_msb_and_sign();
        launch(16'hA000, 16'h9FFF, 1'b0, 1'b0, "msb_u");
        await_done("msb_u");
        launch(16'hA000, 16'h9FFF, 1'b1, 1'b0, "msb_s");
        await_done("msb_s");
        launch(16'h8000, 16'h0001, 1'b1, 1'b0, "signmis_s");
        await_done("signmis_s");
        launch(16'h8000, 16'h0001, 1'b0, 1'b0, "signmis_u");
        await_done("signmis_u");
        check_idle("sign_after");
    endtask

    task automatic test_ignored_start();
        launch(16'h12F4, 16'h12F5, 1'b0, 1'b0, "lastslice");
        @(posedge clk); #1;
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; sgn = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL lastslice busy: busy=%b done=%b expected 1 0", busy, done);
        end
        await_done("lastslice");
        check_idle("lastslice_after1");
        check_idle("lastslice_after2");
    endtask

    task automatic test_back_to_back();
        launch(16'hA0F0, 16'hA0F1, 1'b0, 1'b1, "b2b_first");
        await_done("b2b_first");
        launch(16'h0001, 16'h0002, 1'b0, 1'b0, "b2b_second");
        await_done("b2b_second");
        check_idle("b2b_after");
    endtask

    task automatic test_reset_mid();
        launch(16'h1230, 16'h1231, 1'b0, 1'b0, "rstmid");
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, gt, lt, eq} !== 5'b00000) begin
            n_err++;
            $display("FAIL rstmid async: busy/done/gt/lt/eq=%b%b%b%b%b expected 00000", busy, done, gt, lt, eq);
        end
        cur_gt = 1'b0; cur_lt = 1'b0; cur_eq = 1'b0;
        start = 1'b1; a = 16'hFFFF; b = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 5; i++) check_idle("rstmid_quiet");
        launch(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "rst_eq");
        await_done("rst_eq");
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        for (int n = 0; n < 60; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = W'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (16'h0001 << $urandom_range(0, W - 1));
            endcase
            launch(ra, rb, 1'($urandom), 1'($urandom_range(0, 1)), "random");
            await_done("random");
            if ($urandom_range(0, 2) == 0) begin
                start = 1'b0;
                check_idle("random_gap");
            end
        end
        start = 1'b0;
        check_idle("random_end");
    endtask

    initial begin
        test_reset();
        test_equal();
        test_msb_and_sign();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
